// File: rtl/ula_b_ctrl_fsm.sv
// ula_b_ctrl_fsm: multicycle control FSM for the shared ALU datapath.
// Optional overflow trap on add/sub/addi enabled by defining OVFL_TRAP_EN.
module ula_b_ctrl_fsm #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [3:0] state_out,
  output logic       exception
);
  typedef enum logic [3:0] {
    START    = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    WB_R     = 4'd4,
    EXEC_I   = 4'd5,
    WB_I     = 4'd6,
    MEM_ADDR = 4'd7,
    MEM_RD   = 4'd8,
    MEM_WB   = 4'd9,
    MEM_WR   = 4'd10,
    BRANCH   = 4'd11,
    EXCEPT   = 4'd15
  } state_t;
  localparam logic [2:0] MW = 3'(MEM_WAIT);
  state_t state, nxt;
  logic [2:0] cnt;
  logic last, r_ok, add_sub, trap;
  logic [2:0] r_op;
  logic unused_ok;
  assign unused_ok = ^{zero, overflow};
  assign last = cnt == MW;
  assign add_sub = funct == 6'h20 || funct == 6'h22;
  assign r_op = funct == 6'h20 ? 3'b001 :
                funct == 6'h22 ? 3'b010 :
                funct == 6'h24 ? 3'b011 :
                funct == 6'h25 ? 3'b100 :
                funct == 6'h2A ? 3'b111 : 3'b000;
  assign r_ok = r_op != 3'b000;
`ifdef OVFL_TRAP_EN
  assign trap = overflow;
`else
  assign trap = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= START;
      cnt   <= 3'd0;
    end else begin
      state <= nxt;
      cnt   <= (nxt == state && (state == FETCH || state == MEM_RD)) ? cnt + 3'd1 : 3'd0;
    end
  always_comb begin
    nxt = EXCEPT;
    case (state)
      START:    nxt = FETCH;
      FETCH:    nxt = last ? DECODE : FETCH;
      DECODE:   nxt = opcode == 6'h00 ? (r_ok ? EXEC_R : EXCEPT) :
                      opcode == 6'h08 ? EXEC_I :
                      (opcode == 6'h23 || opcode == 6'h2B) ? MEM_ADDR :
                      opcode == 6'h04 ? BRANCH : EXCEPT;
      EXEC_R:   nxt = (trap && add_sub) ? EXCEPT : WB_R;
      EXEC_I:   nxt = trap ? EXCEPT : WB_I;
      MEM_ADDR: nxt = opcode == 6'h2B ? MEM_WR : MEM_RD;
      MEM_RD:   nxt = last ? MEM_WB : MEM_RD;
      WB_R, WB_I, MEM_WB, MEM_WR, BRANCH: nxt = FETCH;
      default:  nxt = EXCEPT;
    endcase
  end
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    exception     = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = last;
        pc_write  = last;
        alu_src_b = last ? 2'b11 : 2'b00;
        alu_op    = last ? 3'b001 : 3'b000;
      end
      DECODE: begin
        alu_src_b = 2'b10;
        alu_op    = 3'b001;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_op;
      end
      WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      EXEC_I, MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 3'b001;
      end
      WB_I: reg_write = 1'b1;
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b010;
        pc_write_cond = 1'b1;
        pc_src        = 1'b1;
      end
      EXCEPT: exception = 1'b1;
      default: ;
    endcase
  end
  assign state_out = state;
endmodule

// File: tb/tb_ula_b_ctrl_fsm.sv
// tb_ula_b_ctrl_fsm: table vectors, hand corner sequences and random
// instruction streams checked against a per-instruction trace model.
module tb_ula_b_ctrl_fsm;
  localparam int MW = 1;
`ifdef OVFL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  typedef struct packed {
    logic       pc_write, pc_write_cond, pc_src, ir_write, mem_read, mem_write;
    logic       i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state_out;
    logic       exception;
  } out_t;
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         cyc;
    logic [3:0] st;
    logic [2:0] aop;
  } vec_t;
  logic clk = 1'b0, reset = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, overflow = 1'b0;
  logic pc_write, pc_write_cond, pc_src, ir_write, mem_read, mem_write;
  logic i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a, exception;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state_out;
  out_t act;
  out_t exp_q[$];
  int checks = 0, errors = 0;

  ula_b_ctrl_fsm #(.MEM_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state_out(state_out),
    .exception(exception)
  );

  assign act = {pc_write, pc_write_cond, pc_src, ir_write, mem_read, mem_write,
                i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                alu_op, state_out, exception};

  always #5 clk = ~clk;

  task automatic chk_out(input string nm, input out_t a, input out_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", nm, a, e, $time);
    end
  endtask

  function automatic out_t mk(input logic [3:0] s);
    out_t o = '0;
    o.state_out = s;
    return o;
  endfunction

  function automatic logic [2:0] rop(input logic [5:0] fn);
    case (fn)
      6'h20: return 3'b001;
      6'h22: return 3'b010;
      6'h24: return 3'b011;
      6'h25: return 3'b100;
      6'h2A: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  task automatic add_except();
    out_t o = mk(4'd15);
    o.exception = 1'b1;
    repeat (3) exp_q.push_back(o);
  endtask

  // Expected per-cycle output trace of one instruction, starting at the first FETCH cycle.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic ovf);
    out_t o;
    exp_q.delete();
    for (int i = 0; i <= MW; i++) begin
      o = mk(4'd1);
      o.mem_read = 1'b1;
      if (i == MW) begin
        o.ir_write = 1'b1; o.pc_write = 1'b1; o.alu_src_b = 2'b11; o.alu_op = 3'b001;
      end
      exp_q.push_back(o);
    end
    o = mk(4'd2); o.alu_src_b = 2'b10; o.alu_op = 3'b001;
    exp_q.push_back(o);
    if (op == 6'h00 && rop(fn) != 3'b000) begin
      o = mk(4'd3); o.alu_src_a = 1'b1; o.alu_op = rop(fn);
      exp_q.push_back(o);
      if (TRAP && ovf && (fn == 6'h20 || fn == 6'h22)) add_except();
      else begin
        o = mk(4'd4); o.reg_write = 1'b1; o.reg_dst = 1'b1;
        exp_q.push_back(o);
      end
    end else if (op == 6'h08) begin
      o = mk(4'd5); o.alu_src_a = 1'b1; o.alu_src_b = 2'b01; o.alu_op = 3'b001;
      exp_q.push_back(o);
      if (TRAP && ovf) add_except();
      else begin
        o = mk(4'd6); o.reg_write = 1'b1;
        exp_q.push_back(o);
      end
    end else if (op == 6'h23 || op == 6'h2B) begin
      o = mk(4'd7); o.alu_src_a = 1'b1; o.alu_src_b = 2'b01; o.alu_op = 3'b001;
      exp_q.push_back(o);
      if (op == 6'h23) begin
        for (int i = 0; i <= MW; i++) begin
          o = mk(4'd8); o.mem_read = 1'b1; o.i_or_d = 1'b1;
          exp_q.push_back(o);
        end
        o = mk(4'd9); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
        exp_q.push_back(o);
      end else begin
        o = mk(4'd10); o.mem_write = 1'b1; o.i_or_d = 1'b1;
        exp_q.push_back(o);
      end
    end else if (op == 6'h04) begin
      o = mk(4'd11); o.alu_src_a = 1'b1; o.alu_op = 3'b010;
      o.pc_write_cond = 1'b1; o.pc_src = 1'b1;
      exp_q.push_back(o);
    end else add_except();
  endtask

  // Asserts reset away from the clock edge; leaves the DUT in its first FETCH cycle.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1 chk_out("rst_async", act, '0);
    @(posedge clk); #1;
    chk_out("rst_hold", act, '0);
    reset = 1'b1;
    #1 chk_out("rst_start", act, mk(4'd0));
    @(posedge clk); #1;
  endtask

  task automatic run_seq(input string nm, input logic [5:0] op, input logic [5:0] fn,
                         input logic ovf, input int zmode);
    out_t e;
    bit exc = 1'b0;
    opcode = op; funct = fn; overflow = ovf;
    build(op, fn, ovf);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exc = e.exception;
      zero = zmode == 2 ? 1'($urandom_range(0, 1)) : 1'(zmode);
      chk_out(nm, act, e);
      @(posedge clk); #1;
    end
    if (exc) do_reset();
  endtask

  task automatic run_tbl(input vec_t v);
    int n = 0, got_cyc = -1;
    logic [3:0] prev = state_out, got_st = 'x;
    logic [2:0] got_aop = 'x;
    bit done = 1'b0;
    opcode = v.op; funct = v.fn; overflow = 1'b0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (prev == 4'd2) begin
        got_st = state_out; got_aop = alu_op;
      end
      if (state_out == 4'd1 && prev != 4'd1) begin
        got_cyc = n; done = 1'b1;
      end else if (state_out == 4'd15) begin
        got_cyc = 0; done = 1'b1;
      end
      prev = state_out;
    end
    chk_int($sformatf("tbl_cyc op=%h fn=%h", v.op, v.fn), got_cyc, v.cyc);
    chk_int($sformatf("tbl_st op=%h fn=%h", v.op, v.fn), int'(got_st), int'(v.st));
    chk_int($sformatf("tbl_aop op=%h fn=%h", v.op, v.fn), int'(got_aop), int'(v.aop));
    if (state_out != 4'd1) do_reset();
  endtask

  initial begin
    vec_t tbl[11];
    out_t e;
    tbl[0]  = '{6'h00, 6'h20, 5, 4'd3, 3'b001};
    tbl[1]  = '{6'h00, 6'h22, 5, 4'd3, 3'b010};
    tbl[2]  = '{6'h00, 6'h24, 5, 4'd3, 3'b011};
    tbl[3]  = '{6'h00, 6'h25, 5, 4'd3, 3'b100};
    tbl[4]  = '{6'h00, 6'h2A, 5, 4'd3, 3'b111};
    tbl[5]  = '{6'h08, 6'h00, 5, 4'd5, 3'b001};
    tbl[6]  = '{6'h23, 6'h11, 7, 4'd7, 3'b001};
    tbl[7]  = '{6'h2B, 6'h00, 5, 4'd7, 3'b001};
    tbl[8]  = '{6'h04, 6'h00, 4, 4'd11, 3'b010};
    tbl[9]  = '{6'h00, 6'h21, 0, 4'd15, 3'b000};
    tbl[10] = '{6'h3F, 6'h20, 0, 4'd15, 3'b000};
    do_reset();
    for (int i = 0; i < 11; i++) run_tbl(tbl[i]);

    opcode = 6'h23; funct = '0; overflow = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    e = mk(4'd8); e.mem_read = 1'b1; e.i_or_d = 1'b1;
    chk_out("mid_memrd", act, e);
    do_reset();
    e = mk(4'd1); e.mem_read = 1'b1;
    chk_out("post_rst_fetch", act, e);

    run_seq("sub_r", 6'h00, 6'h22, 1'b0, 2);
    run_seq("lw", 6'h23, 6'h00, 1'b0, 2);
    run_seq("beq_z1", 6'h04, 6'h00, 1'b0, 1);
    run_seq("beq_z0", 6'h04, 6'h00, 1'b0, 0);
    run_seq("addi_ovf", 6'h08, 6'h00, 1'b1, 2);
    run_seq("add_ovf", 6'h00, 6'h20, 1'b1, 2);
    run_seq("and_ovf", 6'h00, 6'h24, 1'b1, 2);

    opcode = 6'h3F; funct = '0;
    repeat (MW + 2) begin @(posedge clk); #1; end
    e = mk(4'd15); e.exception = 1'b1;
    for (int i = 0; i < 25; i++) begin
      zero = 1'($urandom_range(0, 1)); overflow = 1'($urandom_range(0, 1));
      opcode = 6'($urandom);
      chk_out("except_sticky", act, e);
      @(posedge clk); #1;
    end
    do_reset();

    for (int i = 0; i < 150; i++) begin
      logic [5:0] op, fn;
      int r = $urandom_range(0, 9);
      fn = r == 8 ? 6'($urandom) : 6'h20 + 6'($urandom_range(0, 10));
      op = r < 3 ? 6'h00 : r == 3 || r == 9 ? 6'h08 : r == 4 ? 6'h23 :
           r == 5 ? 6'h2B : r == 6 ? 6'h04 : r == 8 ? 6'h00 : 6'h10 + 6'($urandom_range(0, 15));
      run_seq("rand", op, fn, 1'($urandom_range(0, 1)), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ula_b_ctrl_fsm.md
Name: ula_b_ctrl_fsm

Overview:
- Multicycle control FSM for the single shared ALU of the CPU datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the ALU operand-B select, the operand-A select, the ALU operation, and all PC, IR, memory and register-file write strobes.
- Sits between the instruction register (opcode/funct) and the datapath muxes and enables.

Parameters:
- MEM_WAIT, 1: extra wait cycles per memory read. Range 0..7. A memory read state lasts MEM_WAIT+1 cycles.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low. 0 = reset.
- opcode  in  6  instruction bits [31:26].
- funct  in  6  instruction bits [5:0].
- zero  in  1  ALU zero flag.
- overflow  in  1  ALU signed-overflow flag.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero=1.
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut register.
- ir_write  out  1  instruction register load.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut.
- reg_write  out  1  register file write.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR.
- alu_src_a  out  1  operand A: 0 = PC, 1 = register A.
- alu_src_b  out  2  operand B: 00 = register B, 01 = sign-extended imm, 10 = sign-extended imm<<2, 11 = constant 4.
- alu_op  out  3  ALU operation: 001 add, 010 sub, 011 and, 100 or, 111 slt.
- state_out  out  4  current state code, for debug.
- exception  out  1  illegal instruction or trap; sticky.

Behaviour:
- Outputs are Moore, decoded combinationally from the state register and the wait counter. Every output is 0 unless listed for the current state.
- Reset low: state=START (0), wait counter=0, so all outputs are 0. Reset takes effect immediately at any point, including mid-instruction or during a memory wait.
- START (0): no outputs asserted. Next state FETCH.
- FETCH (1): mem_read=1, i_or_d=0 for MEM_WAIT+1 cycles, counted by the wait counter.
  - Final cycle only: ir_write=1, pc_write=1, pc_src=0, alu_src_a=0, alu_src_b=11, alu_op=001 (PC+4).
  - Next state DECODE.
- DECODE (2): alu_src_a=0, alu_src_b=10, alu_op=001 (branch target into ALUOut). Dispatch on opcode:
  - 0x00: funct 0x20/0x22/0x24/0x25/0x2A go to EXEC_R; any other funct goes to EXCEPT.
  - 0x08 goes to EXEC_I.
  - 0x23 or 0x2B goes to MEM_ADDR.
  - 0x04 goes to BRANCH.
  - Any other opcode goes to EXCEPT.
- EXEC_R (3): alu_src_a=1, alu_src_b=00, alu_op from funct (add, sub, and, or, slt). Next state WB_R.
- WB_R (4): reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- EXEC_I (5): alu_src_a=1, alu_src_b=01, alu_op=001. Next state WB_I.
- WB_I (6): reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- MEM_ADDR (7): alu_src_a=1, alu_src_b=01, alu_op=001. Next state MEM_RD for lw, MEM_WR for sw. The opcode is held stable by the IR.
- MEM_RD (8): mem_read=1, i_or_d=1 for MEM_WAIT+1 cycles. Next state MEM_WB.
- MEM_WB (9): reg_write=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
- MEM_WR (10): mem_write=1, i_or_d=1 for exactly 1 cycle. Next state FETCH.
- BRANCH (11): alu_src_a=1, alu_src_b=00, alu_op=010, pc_write_cond=1, pc_src=1. Next state FETCH.
- EXCEPT (15): exception=1, all other outputs 0. The FSM stays here until reset.
- Wait counter is 3 bits.
  - Cleared on entry to FETCH and to MEM_RD; increments each cycle in those states.
  - A state exits when counter == MEM_WAIT. MEM_WAIT=0 makes these states single-cycle.
- Cycles per instruction, MEM_WAIT=1: R-type 5, addi 5, lw 7, sw 5, beq 4.
- Unused state codes (12, 13, 14) transition to EXCEPT.

Optional Feature:
- OVFL_TRAP_EN defined: in EXEC_R with funct 0x20/0x22, or in EXEC_I, overflow=1 sampled that cycle sends the FSM to EXCEPT instead of WB. No reg_write occurs.
- OVFL_TRAP_EN undefined: overflow is ignored and the instruction completes normally.

Test Plan:
- Reset low mid-MEM_RD, then release -> all outputs 0 immediately on reset; state_out=0 for 1 cycle after release; FETCH follows with mem_read=1.
- Opcode 0x00, funct 0x22, MEM_WAIT=1 -> FETCH: alu_src_b=11 on its 2nd cycle. EXEC_R: alu_src_b=00, alu_op=010. WB_R: reg_write=1, reg_dst=1. 5 cycles total.
- Opcode 0x23 -> MEM_ADDR: alu_src_b=01. MEM_RD: mem_read=1, i_or_d=1 for 2 cycles. MEM_WB: mem_to_reg=1. Back in FETCH 7 cycles after entering FETCH.
- Opcode 0x04 with zero=1, then with zero=0 -> BRANCH: pc_write_cond=1, pc_src=1, alu_src_b=00, alu_op=010 in both cases; pc_write=0 throughout BRANCH.
- Opcode 0x3F -> EXCEPT; exception=1 held for 20+ cycles; only reset clears it.
- With OVFL_TRAP_EN: opcode 0x08 with overflow=1 in EXEC_I -> EXCEPT, reg_write never asserted. Without the macro: WB_I with reg_write=1.
